// File: rtl/relay_pkg.sv
// Shared encodings for the relay framer: relay modes, FSM states, analog
// front-end modulation codes and the frame start nibbles.
package relay_pkg;

    typedef enum logic [2:0] {
        MODE_SNIFFER     = 3'd0,
        MODE_FAKE_READER = 3'd5,
        MODE_FAKE_TAG    = 3'd6
    } relay_mode_e;

    typedef enum logic {
        ST_LISTEN = 1'b0,
        ST_MOD    = 1'b1
    } relay_state_e;

    localparam logic [2:0] MOD_OFF        = 3'd0;
    localparam logic [2:0] MOD_TAG_LISTEN = 3'd1;
    localparam logic [2:0] MOD_TAG_MOD    = 3'd2;
    localparam logic [2:0] MOD_RDR_LISTEN = 3'd3;
    localparam logic [2:0] MOD_RDR_MOD    = 3'd4;

    localparam logic [3:0] START_READER = 4'hC;
    localparam logic [3:0] START_TAG    = 4'hF;

    // Front-end code for a mode/state pair; unknown modes behave as sniffer.
    function automatic logic [2:0] mod_code(input logic [2:0] mode, input logic in_mod);
        logic [2:0] code;
        code = MOD_OFF;
        if (mode == MODE_FAKE_READER) begin
            code = in_mod ? MOD_RDR_MOD : MOD_RDR_LISTEN;
        end else if (mode == MODE_FAKE_TAG) begin
            code = in_mod ? MOD_TAG_MOD : MOD_TAG_LISTEN;
        end
        return code;
    endfunction

endpackage

// File: rtl/relay_sampler.sv
// Free-running sample divider and relay-bit shift buffer. The tick is
// combinational from the divider count so the framer acts in the same clk.
module relay_sampler #(
    parameter int DIV_LOG2  = 4,
    parameter int DIV_PHASE = 8,
    parameter int BUF_W     = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             flush,
    input  logic             data_in,
    output logic             tick,
    output logic [BUF_W-1:0] shift_buf
);

    logic [DIV_LOG2-1:0] div_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_LOG2'(DIV_PHASE));

    // A mode change flush outranks a coincident sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_buf <= '0;
        end else if (flush) begin
            shift_buf <= '0;
        end else if (tick && shift_en) begin
            shift_buf <= {shift_buf[BUF_W-2:0], data_in};
        end
    end

endmodule

// File: rtl/relay_framer.sv
// Relay framer: detects reader/tag frame start and end in the sampled relay
// stream, assembles bytes, counts frame length and flags overlong frames.
module relay_framer
    import relay_pkg::*;
#(
    parameter int DIV_LOG2       = 4,
    parameter int DIV_PHASE      = 8,
    parameter int BUF_W          = 20,
    parameter int RDR_END_LEN    = 20,
    parameter int TAG_END_LEN    = 12,
    parameter int MAX_FRAME_BITS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic        data_in_decoded,
    input  logic        err_clr,
    output logic [2:0]  mod_type,
    output logic        data_out,
    output logic        tx_gate,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic [15:0] frame_bits,
    output logic        timeout_err
);

    logic             tick;
    logic [BUF_W-1:0] shift_buf_q;
    logic [BUF_W-1:0] buf_post;
    logic             unused_msb;
    logic [2:0]       mode_q;
    logic             mode_changed;
    logic             is_reader;
    logic             is_tag;
    logic             active;

    relay_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d, bit_inc;
    logic [15:0]  frame_bits_q, frame_bits_d, frame_inc;
    logic [7:0]   rx_byte_q, rx_byte_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d, err_set;
    logic [2:0]   mod_type_q, mod_type_d;
    logic         start_hit, rdr_end, tag_end, end_hit;

    assign is_reader    = (mode == MODE_FAKE_READER);
    assign is_tag       = (mode == MODE_FAKE_TAG);
    assign active       = is_reader || is_tag;
    assign mode_changed = (mode != mode_q);

    relay_sampler #(
        .DIV_LOG2 (DIV_LOG2),
        .DIV_PHASE(DIV_PHASE),
        .BUF_W    (BUF_W)
    ) u_sampler (
        .clk      (clk),
        .reset    (reset),
        .shift_en (active),
        .flush    (mode_changed),
        .data_in  (data_in_decoded),
        .tick     (tick),
        .shift_buf(shift_buf_q)
    );

    // Frame decisions look at the buffer as it will be after this tick's shift.
    assign buf_post   = {shift_buf_q[BUF_W-2:0], data_in_decoded};
    assign unused_msb = shift_buf_q[BUF_W-1];

    assign bit_inc   = bit_cnt_q + 3'd1;
    assign frame_inc = (frame_bits_q == 16'hFFFF) ? frame_bits_q : frame_bits_q + 16'd1;

    assign start_hit = (buf_post[3:0] == (is_reader ? START_READER : START_TAG))
                    && (buf_post[BUF_W-1:4] == '0);
    assign rdr_end   = (buf_post[RDR_END_LEN-1:0] == '0)
                    || ((buf_post[RDR_END_LEN-1 -: 4] == START_READER)
                        && (buf_post[RDR_END_LEN-5:0] == '0));
    assign tag_end   = (buf_post[TAG_END_LEN-1:0] == '0);
    assign end_hit   = (bit_inc == 3'd0) && (is_reader ? rdr_end : tag_end);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        frame_bits_d = frame_bits_q;
        rx_byte_d    = rx_byte_q;
        valid_d      = 1'b0;
        err_set      = 1'b0;

        if (mode_changed) begin
            state_d      = ST_LISTEN;
            bit_cnt_d    = 3'd0;
            frame_bits_d = 16'd0;
        end else if (!active) begin
            state_d = ST_LISTEN;
        end else if (tick) begin
            bit_cnt_d = bit_inc;
            if (state_q == ST_LISTEN) begin
                if (start_hit) begin
                    state_d      = ST_MOD;
                    bit_cnt_d    = 3'd0;
                    frame_bits_d = 16'd0;
                end
            end else begin
                frame_bits_d = frame_inc;
                if (bit_inc == 3'd0) begin
                    rx_byte_d = buf_post[7:0];
                    valid_d   = 1'b1;
                end
                // A genuine end on the limit tick is not a timeout.
                if (end_hit) begin
                    state_d = ST_LISTEN;
                end else if (int'(frame_inc) >= MAX_FRAME_BITS) begin
                    state_d = ST_LISTEN;
                    err_set = 1'b1;
                end
            end
        end

        err_d      = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
        mod_type_d = mod_code(mode, state_d == ST_MOD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LISTEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q       <= MODE_SNIFFER;
            bit_cnt_q    <= 3'd0;
            frame_bits_q <= 16'd0;
            rx_byte_q    <= 8'd0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            mod_type_q   <= MOD_OFF;
        end else begin
            mode_q       <= mode;
            bit_cnt_q    <= bit_cnt_d;
            frame_bits_q <= frame_bits_d;
            rx_byte_q    <= rx_byte_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            mod_type_q   <= mod_type_d;
        end
    end

    assign mod_type      = mod_type_q;
    assign data_out      = shift_buf_q[3];
    assign tx_gate       = (state_q == ST_LISTEN);
    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = valid_q;
    assign frame_bits    = frame_bits_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_relay_framer.sv
// Testbench for relay_framer: random relay streams checked against a
// bit-history reference model of reader/tag framing.
module tb_relay_framer;

    localparam int MAXF = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic        data_in_decoded;
    logic        err_clr;
    logic [2:0]  mod_type;
    logic        data_out;
    logic        tx_gate;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [15:0] frame_bits;
    logic        timeout_err;

    relay_framer #(
        .DIV_LOG2      (4),
        .DIV_PHASE     (8),
        .BUF_W         (20),
        .RDR_END_LEN   (20),
        .TAG_END_LEN   (12),
        .MAX_FRAME_BITS(MAXF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .data_in_decoded(data_in_decoded),
        .err_clr        (err_clr),
        .mod_type       (mod_type),
        .data_out       (data_out),
        .tx_gate        (tx_gate),
        .rx_byte        (rx_byte),
        .rx_byte_valid  (rx_byte_valid),
        .frame_bits     (frame_bits),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    // Reference model: history of sampled bits plus frame bookkeeping.
    bit         hist[$];
    bit         m_in_frame;
    int         m_count;
    int         m_frame_bits;
    bit         m_err;
    bit         m_valid;
    logic [7:0] m_rx_byte;
    logic [2:0] m_modtype;
    logic [2:0] m_prev_mode;

    function automatic bit ago(int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_code(logic [2:0] md, bit in_frame);
        if (md == 3'd5) return in_frame ? 3'd4 : 3'd3;
        if (md == 3'd6) return in_frame ? 3'd2 : 3'd1;
        return 3'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_in_frame   = 0;
        m_count      = 0;
        m_frame_bits = 0;
        m_err        = 0;
        m_valid      = 0;
        m_rx_byte    = 8'd0;
        m_modtype    = 3'd0;
        m_prev_mode  = 3'd0;
    endtask

    task automatic model_flush();
        hist.delete();
        m_in_frame   = 0;
        m_count      = 0;
        m_frame_bits = 0;
    endtask

    task automatic model_tick(input bit b, input logic [2:0] md, output bit set_err);
        bit [3:0] pat;
        bit hit;
        bit ended;
        bit allz;
        bit cpat;
        set_err = 0;
        ended   = 0;
        hist.push_back(b);
        if (hist.size() > 32) void'(hist.pop_front());
        if (!m_in_frame) begin
            pat = (md == 3'd5) ? 4'hC : 4'hF;
            hit = ({ago(3), ago(2), ago(1), ago(0)} == pat);
            for (int k = 4; k < 20; k++) if (ago(k)) hit = 0;
            if (hit) begin
                m_in_frame   = 1;
                m_count      = 0;
                m_frame_bits = 0;
            end
        end else begin
            m_count++;
            if (m_frame_bits < 65535) m_frame_bits++;
            if (m_count % 8 == 0) begin
                for (int k = 0; k < 8; k++) m_rx_byte[k] = ago(k);
                m_valid = 1;
                if (md == 3'd5) begin
                    allz = 1;
                    for (int k = 0; k < 20; k++) if (ago(k)) allz = 0;
                    cpat = ({ago(19), ago(18), ago(17), ago(16)} == 4'hC);
                    for (int k = 0; k < 16; k++) if (ago(k)) cpat = 0;
                    ended = allz || cpat;
                end else begin
                    ended = 1;
                    for (int k = 0; k < 12; k++) if (ago(k)) ended = 0;
                end
            end
            if (ended) begin
                m_in_frame = 0;
            end else if (m_frame_bits >= MAXF) begin
                m_in_frame = 0;
                set_err    = 1;
            end
        end
    endtask

    // One clk: model the edge from the inputs presented before it.
    task automatic advance();
        bit tick_now, flush_now, clr_now, set_err, b;
        logic [2:0] md;
        tick_now  = (edge_cnt % 16 == 8);
        flush_now = (mode !== m_prev_mode);
        clr_now   = err_clr;
        md        = mode;
        b         = data_in_decoded;
        @(posedge clk);
        #1;
        edge_cnt++;
        m_prev_mode = md;
        m_valid     = 0;
        set_err     = 0;
        if (flush_now) model_flush();
        else if (tick_now && (md == 3'd5 || md == 3'd6)) model_tick(b, md, set_err);
        if (set_err) m_err = 1;
        else if (clr_now) m_err = 0;
        m_modtype = exp_code(md, m_in_frame);
    endtask

    task automatic send_bit(input bit b);
        data_in_decoded = b;
        while (edge_cnt % 16 != 8) advance();
        advance();
    endtask

    task automatic set_mode(input logic [2:0] m);
        mode = m;
        advance();
    endtask

    task automatic test_reset();
        mode = 3'd5; data_in_decoded = 0; err_clr = 0; reset = 0;
        model_reset();
        #12;
        checks++; if (mod_type !== 3'd0) begin errors++; $display("[TB] FAIL reset_mod_type: got %0d expected 0", mod_type); end
        checks++; if (tx_gate !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_gate: got %b expected 1", tx_gate); end
        checks++; if (rx_byte_valid !== 1'b0 || rx_byte !== 8'd0) begin errors++; $display("[TB] FAIL reset_rx: got %h/%b expected 00/0", rx_byte, rx_byte_valid); end
        checks++; if (frame_bits !== 16'd0 || timeout_err !== 1'b0 || data_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_misc: got fb=%0d err=%b do=%b expected 0", frame_bits, timeout_err, data_out); end
        @(posedge clk); #1;
        reset = 1; edge_cnt = 0;
        advance();
        checks++; if (mod_type !== m_modtype) begin errors++; $display("[TB] FAIL reset_release_mod_type: got %0d expected %0d", mod_type, m_modtype); end
    endtask

    task automatic send_pattern20(input logic [19:0] pat, input string name);
        for (int i = 19; i >= 0; i--) begin
            send_bit(pat[i]);
            checks++; if (mod_type !== m_modtype || tx_gate !== !m_in_frame) begin errors++; $display("[TB] FAIL %s_bit%0d: got mod=%0d gate=%b expected mod=%0d gate=%b", name, i, mod_type, tx_gate, m_modtype, !m_in_frame); end
        end
    endtask

    task automatic test_reader_start();
        send_pattern20(20'h0000C, "rdr_start");
        checks++; if (mod_type !== 3'd4 || tx_gate !== 1'b0 || frame_bits !== 16'd0) begin errors++; $display("[TB] FAIL rdr_start_tick20: got mod=%0d gate=%b fb=%0d expected 4/0/0", mod_type, tx_gate, frame_bits); end
    endtask

    task automatic test_reader_bytes();
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5;
        bytes[1] = 8'($urandom) | 8'h01;
        bytes[2] = 8'($urandom) | 8'h01;
        bytes[3] = {4'($urandom), 4'hC};
        for (int n = 0; n < 4; n++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(bytes[n][i]);
                checks++; if (rx_byte_valid !== m_valid || mod_type !== m_modtype || data_out !== ago(3)) begin errors++; $display("[TB] FAIL rdr_byte%0d_bit%0d: got v=%b mod=%0d do=%b expected v=%b mod=%0d do=%b", n, i, rx_byte_valid, mod_type, data_out, m_valid, m_modtype, ago(3)); end
            end
            checks++; if (rx_byte !== bytes[n] || rx_byte !== m_rx_byte || rx_byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL rdr_byte%0d: got %h v=%b expected %h v=1", n, rx_byte, rx_byte_valid, bytes[n]); end
            advance();
            checks++; if (rx_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdr_byte%0d_strobe_width: got %b expected 0", n, rx_byte_valid); end
        end
        checks++; if (frame_bits !== 16'(m_frame_bits) || frame_bits !== 16'd32) begin errors++; $display("[TB] FAIL rdr_frame_bits: got %0d expected 32", frame_bits); end
    endtask

    task automatic test_reader_end_aligned();
        for (int i = 1; i <= 16; i++) begin
            send_bit(1'b0);
            checks++; if (mod_type !== m_modtype) begin errors++; $display("[TB] FAIL rdr_end_zero%0d: got %0d expected %0d", i, mod_type, m_modtype); end
        end
        checks++; if (mod_type !== 3'd3 || tx_gate !== 1'b1 || rx_byte !== 8'h00 || rx_byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL rdr_end_aligned: got mod=%0d gate=%b byte=%h v=%b expected 3/1/00/1", mod_type, tx_gate, rx_byte, rx_byte_valid); end
    endtask

    task automatic test_reader_end_misaligned();
        logic [7:0] d;
        int nbits;
        bit done;
        send_pattern20(20'h0000C, "rdr_mis_start");
        d = 8'($urandom);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(1'b1);
        send_bit(1'($urandom));
        send_bit(1'($urandom));
        nbits = 11;
        done  = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            send_bit(1'b0);
            nbits++;
            checks++; if (mod_type !== m_modtype || rx_byte_valid !== m_valid) begin errors++; $display("[TB] FAIL rdr_mis_bit%0d: got mod=%0d v=%b expected mod=%0d v=%b", nbits, mod_type, rx_byte_valid, m_modtype, m_valid); end
            if (tx_gate === 1'b1) done = 1;
        end
        checks++; if (!done || nbits != 32) begin errors++; $display("[TB] FAIL rdr_mis_end: got end=%b after %0d bits expected end after 32", done, nbits); end
    endtask

    task automatic test_tag_timeout();
        set_mode(3'd6);
        checks++; if (mod_type !== 3'd1 || frame_bits !== 16'd0) begin errors++; $display("[TB] FAIL tag_enter: got mod=%0d fb=%0d expected 1/0", mod_type, frame_bits); end
        send_pattern20(20'h0000F, "tag_start");
        checks++; if (mod_type !== 3'd2) begin errors++; $display("[TB] FAIL tag_start: got %0d expected 2", mod_type); end
        for (int i = 1; i <= 64; i++) begin
            send_bit(i % 2);
            checks++; if (mod_type !== m_modtype || timeout_err !== m_err || frame_bits !== 16'(m_frame_bits)) begin errors++; $display("[TB] FAIL tag_bit%0d: got mod=%0d err=%b fb=%0d expected mod=%0d err=%b fb=%0d", i, mod_type, timeout_err, frame_bits, m_modtype, m_err, m_frame_bits); end
            if (i == 63) begin
                checks++; if (timeout_err !== 1'b0 || mod_type !== 3'd2) begin errors++; $display("[TB] FAIL tag_before_timeout: got err=%b mod=%0d expected 0/2", timeout_err, mod_type); end
            end
        end
        checks++; if (timeout_err !== 1'b1 || mod_type !== 3'd1 || frame_bits !== 16'd64) begin errors++; $display("[TB] FAIL tag_timeout: got err=%b mod=%0d fb=%0d expected 1/1/64", timeout_err, mod_type, frame_bits); end
        err_clr = 1;
        advance();
        err_clr = 0;
        checks++; if (timeout_err !== 1'b0 || timeout_err !== m_err) begin errors++; $display("[TB] FAIL tag_err_clr: got %b expected 0", timeout_err); end
    endtask

    task automatic test_mode_switch();
        set_mode(3'd5);
        send_pattern20(20'h0000C, "sw_start");
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        checks++; if (tx_gate !== 1'b0 || frame_bits !== 16'd5) begin errors++; $display("[TB] FAIL sw_in_frame: got gate=%b fb=%0d expected 0/5", tx_gate, frame_bits); end
        data_in_decoded = 0;
        set_mode(3'd6);
        checks++; if (mod_type !== 3'd1 || frame_bits !== 16'd0 || tx_gate !== 1'b1) begin errors++; $display("[TB] FAIL sw_flush: got mod=%0d fb=%0d gate=%b expected 1/0/1", mod_type, frame_bits, tx_gate); end
        checks++; if (rx_byte_valid !== 1'b0 || data_out !== 1'b0) begin errors++; $display("[TB] FAIL sw_no_strobe: got v=%b do=%b expected 0/0", rx_byte_valid, data_out); end
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            checks++; if (rx_byte_valid !== 1'b0 || mod_type !== m_modtype) begin errors++; $display("[TB] FAIL sw_after%0d: got v=%b mod=%0d expected 0/%0d", i, rx_byte_valid, mod_type, m_modtype); end
        end
    endtask

    task automatic test_async_reset();
        set_mode(3'd5);
        send_pattern20(20'h0000C, "ar_start");
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        while (edge_cnt % 16 != 7) advance();
        #3;
        reset = 0;
        #1;
        checks++; if (mod_type !== 3'd0 || tx_gate !== 1'b1 || data_out !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ctrl: got mod=%0d gate=%b do=%b expected 0/1/0", mod_type, tx_gate, data_out); end
        checks++; if (rx_byte !== 8'd0 || rx_byte_valid !== 1'b0 || frame_bits !== 16'd0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_data: got byte=%h v=%b fb=%0d err=%b expected 00/0/0/0", rx_byte, rx_byte_valid, frame_bits, timeout_err); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++; if (rx_byte_valid !== 1'b0 || mod_type !== 3'd0) begin errors++; $display("[TB] FAIL async_reset_hold%0d: got v=%b mod=%0d expected 0/0", i, rx_byte_valid, mod_type); end
        end
        reset = 1; edge_cnt = 0;
        model_reset();
        advance();
        checks++; if (mod_type !== m_modtype || tx_gate !== 1'b1 || rx_byte !== 8'd0) begin errors++; $display("[TB] FAIL async_reset_release: got mod=%0d gate=%b byte=%h expected %0d/1/00", mod_type, tx_gate, rx_byte, m_modtype); end
    endtask

    initial begin
        test_reset();
        test_reader_start();
        test_reader_bytes();
        test_reader_end_aligned();
        test_reader_end_misaligned();
        test_tag_timeout();
        test_mode_switch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/relay_framer.md
RELAY_FRAMER -- requirements
Module: relay_framer

Interface
REQ-001 Parameter DIV_LOG2, default 4, meaning sample divider exponent (period 2^DIV_LOG2 clk).
REQ-002 Parameter DIV_PHASE, default 8, meaning divider count at which a sample tick fires.
REQ-003 Parameter BUF_W, default 20, meaning shift-buffer width in bits (>= RDR_END_LEN and >= 12).
REQ-004 Parameter RDR_END_LEN, default 20, meaning trailing bits checked for reader end-of-frame.
REQ-005 Parameter TAG_END_LEN, default 12, meaning trailing bits checked for tag end-of-frame.
REQ-006 Parameter MAX_FRAME_BITS, default 4096, meaning frame length at which a timeout fires.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 mode  input  3  relay mode: SNIFFER=0, FAKE_READER=5, FAKE_TAG=6; other values behave as SNIFFER.
REQ-010 data_in_decoded  input  1  decoded relay bit stream.
REQ-011 err_clr  input  1  synchronous clear of timeout_err.
REQ-012 mod_type  output  3  LISTEN/MOD code for the analog front end.
REQ-013 data_out  output  1  buffer bit 3 (delayed data).
REQ-014 tx_gate  output  1  1 when the encoder may forward raw relay data (state LISTEN).
REQ-015 rx_byte  output  8  last assembled frame byte.
REQ-016 rx_byte_valid  output  1  one-clk strobe, rx_byte updated.
REQ-017 frame_bits  output  16  sample ticks since frame start, saturating at 16'hFFFF.
REQ-018 timeout_err  output  1  sticky timeout flag.

Function
REQ-019 Divider counts 0..2^DIV_LOG2-1 and wraps; a tick occurs in the clk where the count equals DIV_PHASE.
REQ-020 On a tick in FAKE_READER or FAKE_TAG: buf <= {buf[BUF_W-2:0], data_in_decoded}; 3-bit bit_cnt increments (mod 8); all comparisons below use the post-shift buf and post-increment bit_cnt.
REQ-021 Two states: LISTEN and MOD; mod_type = 3 (LISTEN) / 4 (MOD) in FAKE_READER, 1 / 2 in FAKE_TAG, and 0 in SNIFFER with the state held at LISTEN.
REQ-022 Start condition in LISTEN: buf[3:0] equals 4'hC (reader) or 4'hF (tag), and buf[BUF_W-1:4] is all zero -> MOD; clear bit_cnt and frame_bits in the same clk.
REQ-023 End condition in MOD with bit_cnt==0, reader: buf[RDR_END_LEN-1:0] is all zero, or equals 4'hC followed by RDR_END_LEN-4 zeros -> LISTEN.
REQ-024 End condition in MOD with bit_cnt==0, tag: buf[TAG_END_LEN-1:0] is all zero -> LISTEN.
REQ-025 In MOD, each tick with post-increment bit_cnt==0 sets rx_byte <= buf[7:0] and pulses rx_byte_valid for one clk; the end-of-frame tick also emits its byte; the start tick emits none.
REQ-026 frame_bits increments on every MOD tick and saturates.
REQ-027 When frame_bits reaches MAX_FRAME_BITS in MOD without an end condition -> LISTEN and set timeout_err.
REQ-028 End and timeout on the same tick: end wins and timeout_err stays unchanged.
REQ-029 timeout_err clears on err_clr; a simultaneous set wins over clear.
REQ-030 Any change of mode flushes in the next clk: buf=0, bit_cnt=0, frame_bits=0, state=LISTEN; the divider is not reset.
REQ-031 tx_gate = (state==LISTEN); data_out = buf[3]; both are combinational from registers.

Reset
REQ-032 Asserting reset asynchronously forces: divider=0, buf=0, bit_cnt=0, state=LISTEN, mod_type=0, rx_byte=0, rx_byte_valid=0, frame_bits=0, timeout_err=0, tx_gate=1, data_out=0.
REQ-033 A frame in progress when reset asserts is discarded without a byte strobe.

Structure
REQ-034 Mode and mod_type encodings, plus the start nibbles 4'hC and 4'hF, live in shared package relay_pkg.
REQ-035 Divider and shift buffer live in sub-module relay_sampler (outputs tick and buf); the FSM, byte assembly and counters live in relay_framer.

Verification
REQ-036 Reset release, mode=5, stream 16 zeros then 1100 -> mod_type 3->4 at tick 20; tx_gate=0.
REQ-037 FAKE_READER in MOD, 8 bits 0xA5 -> rx_byte=8'hA5 with a single-clk valid at the byte-aligned tick.
REQ-038 FAKE_READER in MOD, 16 byte-aligned zeros after data -> mod_type=3 on the aligned tick; the same stream misaligned by 3 bits -> stays 4 until aligned.
REQ-039 FAKE_TAG, 16 zeros then 1111, then alternating 1/0 bits with MAX_FRAME_BITS=64 -> mod_type=1 at 64 ticks, timeout_err=1; err_clr -> 0.
REQ-040 Mode switches 5->6 mid-frame -> next clk mod_type=1, frame_bits=0, no byte strobe.
REQ-041 Reset asserted mid-frame, asynchronous to clk -> all outputs at reset values immediately.
